fb_rect_fill: RTL
=================

Name: fb_rect_fill

Overview:
- Upstream writer for the 280x192, 24-bit framebuffer RAM that the VGA scan-out stage reads.
- Accepts rectangle-fill commands (origin, size, colour) over a valid/ready handshake.
- Clips each rectangle to the visible area and emits one framebuffer write per cycle in raster order (row-major, left to right).
- The framebuffer write port arbiter can stall it.

Parameters:
- H_RES, 280, pixels per framebuffer row; also the address stride between rows.
- V_RES, 192, framebuffer rows.
- ADR_W, 16, framebuffer address width.
- DATA_W, 24, pixel width, {R[23:16], G[15:8], B[7:0]}.

Ports:
- CLOCK_50  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  9  left column.
- cmd_y  in  8  top row.
- cmd_w  in  9  width in pixels.
- cmd_h  in  8  height in rows.
- cmd_color  in  DATA_W  fill colour.
- fb_we  out  1  write request.
- fb_adr  out  ADR_W  write address, equal to row*H_RES + col.
- fb_d  out  DATA_W  write data.
- fb_stall  in  1  arbiter refuses the current write.
- busy  out  1  high whenever the block is not in IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (synchronous, active-high, dominates every other input):
  - State goes to IDLE.
  - fb_we=0, fb_adr=0, fb_d=0, done=0, busy=0, cmd_ready=1.
  - Reset asserted mid-fill abandons the command immediately; no further writes are issued.
- State machine: IDLE -> SETUP -> FILL -> DONE -> IDLE.
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid & cmd_ready (cycle T). Fields are latched; next state is SETUP.
  - SETUP (T+1), clip and prepare:
    - Command is empty if cmd_x>=H_RES, cmd_y>=V_RES, cmd_w==0 or cmd_h==0.
    - Otherwise effective width ew = min(cmd_w, H_RES-cmd_x) and effective height eh = min(cmd_h, V_RES-cmd_y).
    - Comparisons use 10-bit unsigned arithmetic; no wrap is allowed.
    - Row base = cmd_y*H_RES + cmd_x, computed in ADR_W bits (maximum 53759).
    - Empty command -> DONE. Otherwise -> FILL.
  - FILL:
    - fb_we=1, fb_d=latched colour, fb_adr=current address. The first write is presented at cycle T+2.
    - A write is taken in any cycle with fb_we & !fb_stall.
    - While fb_stall=1, fb_we, fb_adr and fb_d hold their values.
    - On a taken write: column count increments and fb_adr increments by 1.
    - At the end of a row (column count == ew-1): row base += H_RES, fb_adr = new row base, column count resets.
    - The last write taken (row eh-1, column ew-1) -> DONE, with fb_we=0 in the following cycle.
    - Total writes = ew*eh exactly. Back-to-back with no stall: one write per cycle, no bubble between rows.
  - DONE: done=1 for exactly one cycle; fb_we=0; next state IDLE. cmd_ready returns to 1 in the cycle after DONE.
- Command handling:
  - cmd_valid seen outside IDLE is ignored; the sender must hold it until it sees cmd_ready.
  - Command fields are sampled only on acceptance; later changes have no effect.
- Latency with no stall: done is high at T+2+ew*eh. An empty command gives done at T+2.
- busy=1 in SETUP, FILL and DONE.
- fb_adr never leaves [0, H_RES*V_RES-1] while fb_we=1.

Test Plan:
- Fill x=0,y=0,w=2,h=2,color=24'hFF0000, no stall -> writes to adr 0,1,280,281 on cycles T+2..T+5, all with fb_d=FF0000; done at T+6; exactly 4 writes.
- Fill x=278,y=190,w=10,h=10 -> clipped to 2x2; writes to adr 53478,53479,53758,53759 only; done after 4 writes.
- Fill x=300,y=0,w=5,h=5, and separately w=0 -> no fb_we at all; done at T+2; cmd_ready back high at T+3.
- Fill x=5,y=1,w=3,h=1 with fb_stall high for 3 cycles on the second write -> fb_adr holds at 286 with fb_we=1 during the stall; writes taken are 285,286,287 in order; no duplicate or skipped address.
- Assert reset mid-fill of a 10x10 rectangle after 17 writes -> next cycle fb_we=0, busy=0, cmd_ready=1, no done pulse; a new 1x1 command at x=0,y=0 then writes only adr 0.
- Hold cmd_valid high continuously with two different commands -> second is accepted only in the IDLE cycle after the first's done; writes of the two commands never interleave.

Source files
------------

// File: rtl/fb_rect_fill.sv
// Rectangle-fill writer for the 280x192 24-bit framebuffer feeding VGA scan-out.
// Clips each command to the visible area and issues one write per cycle in raster order.
module fb_rect_fill #(
    parameter int H_RES  = 280,
    parameter int V_RES  = 192,
    parameter int ADR_W  = 16,
    parameter int DATA_W = 24
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic              fb_we,
    output logic [ADR_W-1:0]  fb_adr,
    output logic [DATA_W-1:0] fb_d,
    input  logic              fb_stall,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [9:0]       LP_H      = 10'(H_RES);
    localparam logic [9:0]       LP_V      = 10'(V_RES);
    localparam logic [ADR_W-1:0] LP_STRIDE = ADR_W'(H_RES);

    state_t              r_state;
    logic                r_ready;
    logic                r_we;
    logic [ADR_W-1:0]    r_adr;
    logic [DATA_W-1:0]   r_d;
    logic                r_busy;
    logic                r_done;

    logic [8:0]          r_x;
    logic [7:0]          r_y;
    logic [8:0]          r_w;
    logic [7:0]          r_h;
    logic [DATA_W-1:0]   r_color;

    logic [9:0]          r_ew;
    logic [9:0]          r_eh;
    logic [9:0]          r_col;
    logic [9:0]          r_row;
    logic [ADR_W-1:0]    r_rowBase;

    logic [9:0]          w_x10;
    logic [9:0]          w_y10;
    logic [9:0]          w_w10;
    logic [9:0]          w_h10;
    logic                w_empty;
    logic [9:0]          w_remX;
    logic [9:0]          w_remY;
    logic [9:0]          w_ew;
    logic [9:0]          w_eh;
    logic [ADR_W-1:0]    w_rowBase;
    logic                w_take;
    logic                w_lastCol;
    logic                w_lastRow;

    // Clipping works in 10 bits so H_RES - x never wraps for any legal 9-bit x below H_RES.
    assign w_x10     = {1'b0, r_x};
    assign w_y10     = {2'b00, r_y};
    assign w_w10     = {1'b0, r_w};
    assign w_h10     = {2'b00, r_h};
    assign w_empty   = (w_x10 >= LP_H) || (w_y10 >= LP_V) || (r_w == 9'd0) || (r_h == 8'd0);
    assign w_remX    = LP_H - w_x10;
    assign w_remY    = LP_V - w_y10;
    assign w_ew      = (w_w10 < w_remX) ? w_w10 : w_remX;
    assign w_eh      = (w_h10 < w_remY) ? w_h10 : w_remY;
    assign w_rowBase = (ADR_W'(r_y) * LP_STRIDE) + ADR_W'(r_x);

    assign w_take    = r_we && !fb_stall;
    assign w_lastCol = (r_col == (r_ew - 10'd1));
    assign w_lastRow = (r_row == (r_eh - 10'd1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_d       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_color   <= '0;
            r_ew      <= '0;
            r_eh      <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rowBase <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (cmd_valid && r_ready) begin
                        r_x     <= cmd_x;
                        r_y     <= cmd_y;
                        r_w     <= cmd_w;
                        r_h     <= cmd_h;
                        r_color <= cmd_color;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ew      <= w_ew;
                        r_eh      <= w_eh;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_rowBase <= w_rowBase;
                        r_adr     <= w_rowBase;
                        r_d       <= r_color;
                        r_we      <= 1'b1;
                        r_state   <= S_FILL;
                    end
                end

                // A stalled write leaves every output untouched; only a taken write advances.
                S_FILL: begin
                    if (w_take) begin
                        if (w_lastCol) begin
                            if (w_lastRow) begin
                                r_we    <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_col     <= '0;
                                r_row     <= r_row + 10'd1;
                                r_rowBase <= r_rowBase + LP_STRIDE;
                                r_adr     <= r_rowBase + LP_STRIDE;
                            end
                        end else begin
                            r_col <= r_col + 10'd1;
                            r_adr <= r_adr + ADR_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign fb_we     = r_we;
    assign fb_adr    = r_adr;
    assign fb_d      = r_d;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
